// File: rtl/exec_branch_stats_pkg.sv
// Shared constants for the execute stage: datapath width, halt code, ALU op encodings.
package exec_branch_stats_pkg;

  localparam int          WIDTH     = 32;
  localparam logic [31:0] HALT_CODE = 32'd10;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_DIV  = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: shifts act on y, MUL/DIV also produce a secondary word.
module exec_alu
  import exec_branch_stats_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [3:0]   alu_op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [4:0]   shamt,
  output logic [W-1:0] result1,
  output logic [W-1:0] result2
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   quot, rem;
  logic           div_zero, div_ovf;

  // Sign-extend to full width first so an unsigned multiply yields the signed 64-bit product.
  assign prod = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};

  // The two divide corner cases are overridden explicitly; the native operators truncate toward zero.
  assign div_zero = (y == '0);
  assign div_ovf  = (x == {1'b1, {(W-1){1'b0}}}) && (y == '1);

  // Quotient/remainder with corner cases folded in
  always_comb begin
    quot = '0;
    rem  = '0;
    if (div_zero) begin
      quot = '1;
      rem  = x;
    end else if (div_ovf) begin
      quot = x;
      rem  = '0;
    end else begin
      quot = $signed(x) / $signed(y);
      rem  = $signed(x) % $signed(y);
    end
  end

  // Op decode; result2 is only nonzero for MUL and DIV
  always_comb begin
    result1 = '0;
    result2 = '0;
    case (alu_op)
      ALU_SLL:  result1 = y << shamt;
      ALU_SRA:  result1 = $signed(y) >>> shamt;
      ALU_SRL:  result1 = y >> shamt;
      ALU_MUL:  begin result1 = prod[W-1:0]; result2 = prod[2*W-1:W]; end
      ALU_DIV:  begin result1 = quot;        result2 = rem;            end
      ALU_ADD:  result1 = x + y;
      ALU_SUB:  result1 = x - y;
      ALU_AND:  result1 = x & y;
      ALU_OR:   result1 = x | y;
      ALU_XOR:  result1 = x ^ y;
      ALU_NOR:  result1 = ~(x | y);
      ALU_SLT:  result1 = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
      ALU_SLTU: result1 = {{(W-1){1'b0}}, (x < y)};
      default:  ;
    endcase
  end

endmodule

// File: rtl/exec_branch_stats.sv
// Execute stage: ALU, branch decision and free-running cycle/branch/jump counters.
module exec_branch_stats
  import exec_branch_stats_pkg::*;
#(
  parameter int                 WIDTH     = exec_branch_stats_pkg::WIDTH,
  parameter logic [WIDTH-1:0]   HALT_CODE = exec_branch_stats_pkg::HALT_CODE
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [4:0]       shamt,
  input  logic             beq,
  input  logic             bne,
  input  logic             bgtz,
  input  logic             jmp,
  input  logic             syscall,
  output logic [WIDTH-1:0] result1,
  output logic [WIDTH-1:0] result2,
  output logic             equal,
  output logic             branch_out,
  output logic [WIDTH-1:0] count_all,
  output logic [WIDTH-1:0] count_branch,
  output logic [WIDTH-1:0] count_jmp
);

  // Counters power up at zero so the display is sane before the first reset.
  logic [WIDTH-1:0] cnt_all_q = '0;
  logic [WIDTH-1:0] cnt_br_q  = '0;
  logic [WIDTH-1:0] cnt_jmp_q = '0;
  logic             x_gtz, halt;

  exec_alu #(.W(WIDTH)) u_alu (
    .alu_op  (alu_op),
    .x       (x),
    .y       (y),
    .shamt   (shamt),
    .result1 (result1),
    .result2 (result2)
  );

  assign equal      = (x == y);
  assign x_gtz      = ~x[WIDTH-1] & (x != '0);
  assign branch_out = (beq & equal) | (bne & ~equal) | (bgtz & x_gtz);
  assign halt       = syscall & (x == HALT_CODE);

  // Performance counters: clr wins, a halting syscall freezes everything, otherwise count.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_all_q <= '0;
      cnt_br_q  <= '0;
      cnt_jmp_q <= '0;
    end else if (!halt) begin
      cnt_all_q <= cnt_all_q + WIDTH'(1);
      if (branch_out) cnt_br_q  <= cnt_br_q  + WIDTH'(1);
      if (jmp)        cnt_jmp_q <= cnt_jmp_q + WIDTH'(1);
    end
  end

  assign count_all    = cnt_all_q;
  assign count_branch = cnt_br_q;
  assign count_jmp    = cnt_jmp_q;

endmodule

// File: tb/tb_exec_branch_stats.sv
// Directed bench: ALU vector table, branch decisions, counter sequences.
module tb_exec_branch_stats;
  import exec_branch_stats_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  alu_op;
  logic [31:0] x, y;
  logic [4:0]  shamt;
  logic        beq, bne, bgtz, jmp, syscall;
  logic [31:0] result1, result2;
  logic        equal, branch_out;
  logic [31:0] count_all, count_branch, count_jmp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exec_branch_stats dut (
    .clk          (clk),
    .clr          (clr),
    .alu_op       (alu_op),
    .x            (x),
    .y            (y),
    .shamt        (shamt),
    .beq          (beq),
    .bne          (bne),
    .bgtz         (bgtz),
    .jmp          (jmp),
    .syscall      (syscall),
    .result1      (result1),
    .result2      (result2),
    .equal        (equal),
    .branch_out   (branch_out),
    .count_all    (count_all),
    .count_branch (count_branch),
    .count_jmp    (count_jmp)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] xv;
    logic [31:0] yv;
    logic [4:0]  sh;
    logic [31:0] e1;
    logic [31:0] e2;
  } alu_vec_t;

  alu_vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] xv, input logic [31:0] yv,
                         input logic [4:0] sh, input logic [31:0] e1, input logic [31:0] e2);
    alu_vec_t v;
    v.op = op; v.xv = xv; v.yv = yv; v.sh = sh; v.e1 = e1; v.e2 = e2;
    vecs.push_back(v);
  endtask

  // Drive one cycle of control inputs away from the edge, then sample just after the edge.
  task automatic cyc(input logic c, input logic b, input logic j, input logic s,
                     input logic [31:0] xv, input logic [31:0] yv);
    @(negedge clk);
    clr = c; beq = b; jmp = j; syscall = s; x = xv; y = yv;
    bne = 1'b0; bgtz = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int a, input int b, input int j);
    chk({tag, ".all"}, count_all,    32'(a));
    chk({tag, ".br"},  count_branch, 32'(b));
    chk({tag, ".jmp"}, count_jmp,    32'(j));
  endtask

  initial begin
    clr = 1'b0; alu_op = ALU_ADD; x = '0; y = '0; shamt = '0;
    beq = 1'b0; bne = 1'b0; bgtz = 1'b0; jmp = 1'b0; syscall = 1'b0;

    // Power-up value before any clock edge
    #1;
    chk_cnt("t0", 0, 0, 0);

    // ALU table
    add_vec(ALU_ADD,  32'd7,        32'd5,        5'd0, 32'd12,       32'd0);
    add_vec(ALU_SUB,  32'd7,        32'd5,        5'd0, 32'd2,        32'd0);
    add_vec(ALU_ADD,  32'hFFFFFFFF, 32'd2,        5'd0, 32'd1,        32'd0);
    add_vec(ALU_SLT,  32'hFFFFFFFF, 32'd1,        5'd0, 32'd1,        32'd0);
    add_vec(ALU_SLTU, 32'hFFFFFFFF, 32'd1,        5'd0, 32'd0,        32'd0);
    add_vec(ALU_NOR,  32'd0,        32'd0,        5'd0, 32'hFFFFFFFF, 32'd0);
    add_vec(ALU_AND,  32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 32'd0);
    add_vec(ALU_OR,   32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000FFF0, 32'd0);
    add_vec(ALU_XOR,  32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h00000FF0, 32'd0);
    add_vec(ALU_SLL,  32'd0,        32'h80000010, 5'd4, 32'h00000100, 32'd0);
    add_vec(ALU_SRL,  32'd0,        32'h80000010, 5'd4, 32'h08000001, 32'd0);
    add_vec(ALU_SRA,  32'd0,        32'h80000010, 5'd4, 32'hF8000001, 32'd0);
    add_vec(ALU_MUL,  32'h00010000, 32'h00010000, 5'd0, 32'd0,        32'd1);
    add_vec(ALU_MUL,  32'hFFFFFFFE, 32'd3,        5'd0, 32'hFFFFFFFA, 32'hFFFFFFFF);
    add_vec(ALU_DIV,  32'hFFFFFFF9, 32'd2,        5'd0, 32'hFFFFFFFD, 32'hFFFFFFFF);
    add_vec(ALU_DIV,  32'd7,        32'hFFFFFFFE, 5'd0, 32'hFFFFFFFD, 32'd1);
    add_vec(ALU_DIV,  32'd123,      32'd0,        5'd0, 32'hFFFFFFFF, 32'd123);
    add_vec(ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 32'd0);
    add_vec(4'd13,    32'd5,        32'd5,        5'd3, 32'd0,        32'd0);
    add_vec(4'd15,    32'hFFFFFFFF, 32'd9,        5'd1, 32'd0,        32'd0);

    foreach (vecs[i]) begin
      alu_op = vecs[i].op; x = vecs[i].xv; y = vecs[i].yv; shamt = vecs[i].sh;
      #1;
      chk($sformatf("alu[%0d].r1", i), result1, vecs[i].e1);
      chk($sformatf("alu[%0d].r2", i), result2, vecs[i].e2);
    end

    // Branch decisions
    x = 32'd5; y = 32'd5; beq = 1'b1; #1;
    chk("equal", {31'd0, equal}, 32'd1);
    chk("beq_eq", {31'd0, branch_out}, 32'd1);
    beq = 1'b0; bne = 1'b1; #1;
    chk("bne_eq", {31'd0, branch_out}, 32'd0);
    y = 32'd6; #1;
    chk("bne_ne", {31'd0, branch_out}, 32'd1);
    bne = 1'b0; bgtz = 1'b1;
    x = 32'd0; #1;          chk("bgtz0",   {31'd0, branch_out}, 32'd0);
    x = 32'd1; #1;          chk("bgtz1",   {31'd0, branch_out}, 32'd1);
    x = 32'h80000000; #1;   chk("bgtzneg", {31'd0, branch_out}, 32'd0);
    bgtz = 1'b0;

    // Counters: reset, then 10 cycles with 3 taken beq and 2 jmp (one overlapping)
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk_cnt("rst", 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3);  // taken
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 32'd4);  // taken + jmp
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd9, 32'd9);  // taken
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd2);  // not taken
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);  // jmp
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk_cnt("run10", 10, 3, 2);

    // Non-halt syscall counts as a normal cycle
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd0);
    chk_cnt("sys1", 11, 3, 2);

    // Halt syscall held 4 cycles freezes everything, even with beq/jmp asserted
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd10, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'd10, 32'd10);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd10, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'd10, 32'd0);
    chk_cnt("halt", 11, 3, 2);

    // Mid-run clear, with a halt present to show clr wins
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'd10, 32'd10);
    chk_cnt("clr", 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk_cnt("resume", 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
